// File: rtl/cycle_sequencer.sv
// cycle_sequencer: instruction-cycle sequencer for the Nandy core.
// Memory-class instructions (inst[7]=1) take two phases and all others take one.
// The block produces the retire strobe and waits on mem_rdy, forcing a retire
// with a bus_err pulse after TIMEOUT wait cycles. Between instructions it
// injects prioritised interrupts, where the lowest-indexed line wins.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   inst         instruction register contents (bit 7 = memory class)
//   mem_rdy      memory access complete (looked at only in phase 1)
//   cli          return-from-interrupt decode; acts only when retiring
//   irq          interrupt request lines, synchronous to clk
//   cycle        phase bit to control (0 = first phase, 1 = second phase)
//   fetch_en     instruction retires; PC/IR advance at this edge
//   stall        phase 1 waiting on mem_rdy
//   int_take     interrupt entry cycle; PC mux selects vector
//   int_vec      index of interrupt being taken (valid with int_take)
//   in_svc       interrupt in service; further entries masked
//   bus_err      one-cycle pulse on a timeout retire
module cycle_sequencer #(
   parameter int TIMEOUT = 15,
   parameter int NIRQ    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      inst,
   input  logic            mem_rdy,
   input  logic            cli,
   input  logic [NIRQ-1:0] irq,
   output logic            cycle,
   output logic            fetch_en,
   output logic            stall,
   output logic            int_take,
   output logic [2:0]      int_vec,
   output logic            in_svc,
   output logic            bus_err
);

   typedef enum logic [1:0] {RST, PH0, PH1, INT} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t          state, state_nxt;
   logic [7:0]      cnt, cnt_nxt;
   logic [NIRQ-1:0] pend, irq_q, pend_set, pend_clr;
   logic [2:0]      vec;
   logic            int_ok;

   // Lowest-indexed pending line has priority.
   always_comb begin
      vec = '0;
      for (int i = NIRQ - 1; i >= 0; i--)
         if (pend[i]) vec = 3'(i);
   end

   // Entry decision uses in_svc as it was before any same-cycle cli clear.
   // As a result, at least one instruction runs after a return.
   assign int_ok = (|pend) & ~in_svc;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fetch_en  = 1'b0;
      stall     = 1'b0;
      int_take  = 1'b0;
      int_vec   = '0;
      bus_err   = 1'b0;
      case (state)
         RST: state_nxt = PH0;
         PH0: begin
            if (inst[7]) begin
               state_nxt = PH1;
               cnt_nxt   = '0;
            end else begin
               fetch_en  = 1'b1;
               state_nxt = int_ok ? INT : PH0;
            end
         end
         PH1: begin
            if (mem_rdy) begin
               fetch_en  = 1'b1;
               state_nxt = int_ok ? INT : PH0;
            end else if (cnt < TMO) begin
               stall   = 1'b1;
               cnt_nxt = cnt + 8'd1;
            end else begin
               // Timeout: retire anyway and flag the bus error.
               fetch_en  = 1'b1;
               bus_err   = 1'b1;
               state_nxt = int_ok ? INT : PH0;
            end
         end
         INT: begin
            int_take  = 1'b1;
            fetch_en  = 1'b1;
            int_vec   = vec;
            state_nxt = PH0;
         end
         default: state_nxt = RST;
      endcase
   end

   assign cycle = (state == PH1);

   assign pend_set = irq & ~irq_q;
   assign pend_clr = int_take ? (NIRQ'(1) << vec) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RST;
         cnt    <= '0;
         pend   <= '0;
         irq_q  <= '0;
         in_svc <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         irq_q <= irq;
         // A new edge wins over the clear of the line being taken.
         pend  <= (pend & ~pend_clr) | pend_set;
         if (int_take)
            in_svc <= 1'b1;
         else if (cli && fetch_en)
            in_svc <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: directed test-plan sequences plus randomized traffic.
// The sequencer is checked every cycle against an instruction-level reference model.
module tb_cycle_sequencer;

   localparam int TIMEOUT = 3;
   localparam int NIRQ    = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [7:0]      inst = 8'h00;
   logic            mem_rdy = 1'b0;
   logic            cli = 1'b0;
   logic [NIRQ-1:0] irq = '0;
   logic            cycle, fetch_en, stall, int_take, in_svc, bus_err;
   logic [2:0]      int_vec;

   cycle_sequencer #(.TIMEOUT(TIMEOUT), .NIRQ(NIRQ)) dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .mem_rdy(mem_rdy), .cli(cli),
      .irq(irq), .cycle(cycle), .fetch_en(fetch_en), .stall(stall),
      .int_take(int_take), .int_vec(int_vec), .in_svc(in_svc), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Reference model: the model tracks whether the core is out of reset,
   // whether it is in the second phase of a memory instruction,
   // how long it has waited, and whether an interrupt entry is due next.
   bit              m_started, m_second, m_int_due, m_svc;
   int              m_waits;
   logic [NIRQ-1:0] m_pend, m_prev;
   bit              e_cyc, e_fe, e_st, e_it, e_be;
   int              e_vec;

   function automatic int lowest(input logic [NIRQ-1:0] p);
      for (int i = 0; i < NIRQ; i++) if (p[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_started = 0; m_second = 0; m_int_due = 0; m_svc = 0;
      m_waits = 0; m_pend = '0; m_prev = '0;
   endtask

   task automatic model_outs();
      e_cyc = m_second; e_fe = 0; e_st = 0; e_it = 0; e_be = 0; e_vec = 0;
      if (!m_started) begin
         e_cyc = 0;
      end else if (m_int_due) begin
         e_it = 1; e_fe = 1; e_vec = lowest(m_pend);
      end else if (m_second) begin
         if (mem_rdy) e_fe = 1;
         else if (m_waits < TIMEOUT) e_st = 1;
         else begin e_fe = 1; e_be = 1; end
      end else if (!inst[7]) begin
         e_fe = 1;
      end
   endtask

   task automatic model_edge();
      bit any_old, svc_old, sec_old, retire;
      any_old = |m_pend;
      svc_old = m_svc;
      sec_old = m_second;
      retire  = e_fe && !e_it;
      for (int i = 0; i < NIRQ; i++) begin
         if (e_it && i == e_vec) m_pend[i] = 1'b0;
         if (irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
      end
      m_prev = irq;
      if (e_it) m_svc = 1;
      else if (cli && e_fe) m_svc = 0;
      if (!m_started || e_it) m_second = 0;
      else if (sec_old) m_second = !e_fe;
      else m_second = inst[7];
      if (m_started && !sec_old && !e_it && inst[7]) m_waits = 0;
      else if (e_st) m_waits++;
      m_int_due = retire && any_old && !svc_old;
      m_started = 1;
   endtask

   task automatic settle(input string tag);
      #1;
      model_outs();
      chk({tag, ".cycle"},    32'(cycle),    32'(e_cyc));
      chk({tag, ".fetch_en"}, 32'(fetch_en), 32'(e_fe));
      chk({tag, ".stall"},    32'(stall),    32'(e_st));
      chk({tag, ".int_take"}, 32'(int_take), 32'(e_it));
      chk({tag, ".int_vec"},  32'(int_vec),  32'(e_vec));
      chk({tag, ".in_svc"},   32'(in_svc),   32'(m_svc));
      chk({tag, ".bus_err"},  32'(bus_err),  32'(e_be));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step(input string tag);
      settle(tag);
      tick();
   endtask

   // Reset is asserted between edges. The outputs are checked while reset is
   // low, before any clock edge arrives. The release is also away from an edge.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      model_reset();
      settle(tag);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #2;
      // Reset, then a held one-cycle instruction.
      inst = 8'h45;
      do_reset("rst");
      settle("alu0");
      chk("alu0.first_no_retire", 32'(fetch_en), 32'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         settle("alu");
         chk("alu.retire", 32'(fetch_en), 32'd1);
         tick();
      end

      // Memory instruction, ready immediately.
      inst = 8'h90; mem_rdy = 1'b1;
      step("mem_p0");
      settle("mem_p1");
      chk("mem_p1.cycle", 32'(cycle), 32'd1);
      tick();
      inst = 8'h45;
      step("mem_after");

      // Memory instruction timing out.
      inst = 8'hA0; mem_rdy = 1'b0;
      step("tmo_p0");
      for (int k = 0; k < TIMEOUT; k++) begin
         settle("tmo_wait");
         chk("tmo_wait.stall", 32'(stall), 32'd1);
         tick();
      end
      settle("tmo_ret");
      chk("tmo_ret.bus_err", 32'(bus_err), 32'd1);
      tick();
      inst = 8'h45;
      step("tmo_after");

      // Two lines rise together. Line 1 is taken first and line 2 waits for a return.
      irq = 4'b0110;
      step("irq_a");
      step("irq_b");
      settle("irq_int");
      chk("irq_int.vec", 32'(int_vec), 32'd1);
      tick();
      for (int k = 0; k < 3; k++) step("irq_masked");
      cli = 1'b1;
      step("irq_cli");
      cli = 1'b0;
      settle("irq_post_cli");
      chk("irq_post_cli.no_take", 32'(int_take), 32'd0);
      tick();
      settle("irq_int2");
      chk("irq_int2.vec", 32'(int_vec), 32'd2);
      tick();

      // cli retires with pend[0] set. The next cycle is PH0 and entry follows it.
      irq = 4'b0111;
      step("cli0_a");
      step("cli0_b");
      cli = 1'b1;
      step("cli0_ret");
      cli = 1'b0;
      settle("cli0_ph0");
      chk("cli0_ph0.no_take", 32'(int_take), 32'd0);
      tick();
      settle("cli0_int");
      chk("cli0_int.take", 32'(int_take), 32'd1);
      chk("cli0_int.vec", 32'(int_vec), 32'd0);
      tick();

      // Reset in a stall while pend[0] is held.
      irq = 4'b0000;
      step("rs_a");
      irq = 4'b0001; inst = 8'hA0; mem_rdy = 1'b0;
      step("rs_p0");
      step("rs_stall");
      irq = 4'b0000;
      do_reset("rs_rst");
      inst = 8'h45;
      for (int k = 0; k < 5; k++) begin
         settle("rs_after");
         chk("rs_after.no_take", 32'(int_take), 32'd0);
         tick();
      end

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 3000; k++) begin
         inst    = 8'($urandom);
         mem_rdy = ($urandom_range(0, 9) < 3);
         cli     = ($urandom_range(0, 9) == 0);
         for (int i = 0; i < NIRQ; i++)
            if ($urandom_range(0, 19) == 0) irq[i] = ~irq[i];
         if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
         else step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
